// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and widths for the FIFO write-port arbiter.
// Also holds the modulo-increment helper used for the round-robin pointer.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  localparam int IDX_W       = 3;
  localparam int BURST_CNT_W = 4;
  localparam int COUNT_W     = 16;

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] i,
    input int               n
  );
    if (int'(i) + 1 >= n)
      return '0;
    return i + IDX_W'(1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester + FIFO write-side bundle for the write arbiter.
// master = requesters/FIFO side, slave = arbiter side.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_LINES = 8
);
  import fifo_arb_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_LINES-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          half_full;
  logic                          winc;
  logic [DATA_LINES-1:0]         wdata;
  logic                          busy;
  logic [IDX_W-1:0]              grant_id;
  logic [COUNT_W-1:0]            write_count;

  modport master (
    output req, req_data, wfull, half_full,
    input  req_ready, winc, wdata,
    input  busy, grant_id, write_count
  );

  modport slave (
    input  req, req_data, wfull, half_full,
    output req_ready, winc, wdata,
    output busy, grant_id, write_count
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Round-robin picker: first set bit of eligible at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_k;
  int                 w_sum;

  // rotate so bit 0 is the pointer position
  assign w_rot = NUM_REQ'({i_eligible, i_eligible} >> i_rr_ptr);

  always_comb begin
    o_found = 1'b0;
    w_k     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_k     = k;
      end
    end
    w_sum = int'(i_rr_ptr) + w_k;
    if (w_sum >= NUM_REQ)
      w_sum = w_sum - NUM_REQ;
    o_idx = IDX_W'(w_sum);
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port
// among NUM_REQ requesters, with half-full throttling of low-priority ones.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int                 NUM_REQ     = 4,
  parameter int                 DATA_LINES  = 8,
  parameter int                 BURST_LEN   = 4,
  parameter logic [NUM_REQ-1:0] LOWPRI_MASK = NUM_REQ'(4'b1000)
) (
  input logic                 wclk,
  input logic                 wrst,
  fifo_write_arbiter_if.slave bus
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       w_rr_ptr_nxt;
  logic [IDX_W-1:0]       r_owner;
  logic [IDX_W-1:0]       w_owner_nxt;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic [BURST_CNT_W-1:0] w_burst_cnt_nxt;
  logic [COUNT_W-1:0]     r_write_count;

  logic [NUM_REQ-1:0]     w_eligible;
  logic                   w_found;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_own_req;
  logic                   w_own_low;
  logic [DATA_LINES-1:0]  w_own_data;
  logic                   w_hold;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_exit;

  assign w_eligible =
    bus.req & ~(bus.half_full ? LOWPRI_MASK : '0);

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .i_eligible (w_eligible),
    .i_rr_ptr   (r_rr_ptr),
    .o_found    (w_found),
    .o_idx      (w_pick)
  );

  assign w_own_req  = 1'(bus.req >> r_owner);
  assign w_own_low  = 1'(LOWPRI_MASK >> r_owner);
  assign w_own_data = DATA_LINES'(
    bus.req_data >> (int'(r_owner) * DATA_LINES));

  assign w_hold   = (r_state == HOLD);
  assign w_accept = w_hold & w_own_req & ~bus.wfull;
  assign w_last   =
    (r_burst_cnt == BURST_CNT_W'(BURST_LEN - 1));
  // a stalled low-priority owner yields once half_full rises
  assign w_exit   = (w_accept & w_last)
                  | ~w_own_req
                  | (w_own_low & bus.half_full & ~w_accept);

  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = r_burst_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt     = HOLD;
          w_owner_nxt     = w_pick;
          w_burst_cnt_nxt = '0;
        end
      end
      HOLD: begin
        if (w_accept)
          w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        if (w_exit) begin
          w_state_nxt     = IDLE;
          w_rr_ptr_nxt    = wrap_inc(r_owner, NUM_REQ);
          w_burst_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_owner       <= '0;
      r_burst_cnt   <= '0;
      r_write_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      if (w_accept)
        r_write_count <= r_write_count + 1'b1;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    bus.winc      = w_accept;
    bus.wdata     = '0;
    if (w_hold && !bus.wfull)
      bus.req_ready = NUM_REQ'(1) << r_owner;
    if (w_accept)
      bus.wdata = w_own_data;
  end

  assign bus.busy        = w_hold;
  assign bus.grant_id    = r_owner;
  assign bus.write_count = r_write_count;

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Write-side arbiter that shares the single write port of Async_FIFO among NUM_REQ requesters in the wclk domain. It uses round-robin grant with bounded bursts. Low-priority requesters are throttled while the FIFO reports half_full. It drives winc/wdata directly and honours wfull backpressure, so no requester word is lost or duplicated.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_LINES, 8, FIFO data width; matches Async_FIFO DATA_LINES
BURST_LEN, 4, maximum accepted writes per grant before forced rotation (1..15)
LOWPRI_MASK, 4'b1000, bit i set = requester i is blocked while half_full is high

Ports:
wclk  in  1  write-domain clock
wrst  in  1  reset; synchronous to wclk, active-high
req  in  NUM_REQ  per-requester valid
req_data  in  NUM_REQ*DATA_LINES  packed data; requester i occupies bits [i*DATA_LINES +: DATA_LINES]
req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when req[i] & req_ready[i]
wfull  in  1  FIFO full flag (wclk domain)
half_full  in  1  FIFO half-full flag (wclk domain)
winc  out  1  FIFO write enable
wdata  out  DATA_LINES  FIFO write data
busy  out  1  high in HOLD state
grant_id  out  3  current owner index; valid only when busy
write_count  out  16  total accepted writes; wraps at 16'hFFFF -> 0

Behaviour:
- Reset (wrst=1 at posedge wclk):
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, write_count=0.
  - Outputs busy=0, winc=0, req_ready=0, wdata=0, grant_id=0.
- eligible = req & ~(half_full ? LOWPRI_MASK : 0).
- IDLE:
  - winc=0, req_ready=0.
  - If eligible != 0: owner <= first set bit of eligible searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ); state <= HOLD; burst_cnt <= 0.
  - Otherwise stay in IDLE.
- HOLD (combinational outputs):
  - req_ready[owner] = !wfull; all other req_ready bits = 0.
  - winc = req[owner] & !wfull.
  - wdata = req_data[owner] while winc=1, else 0.
- Accept (winc=1): write_count += 1; burst_cnt += 1.
- Exit HOLD -> IDLE at the clock edge when any of the following holds:
  - (a) accept with burst_cnt == BURST_LEN-1;
  - (b) req[owner] == 0;
  - (c) LOWPRI_MASK[owner] & half_full, with no accept that cycle.
  - On exit: rr_ptr <= (owner+1) mod NUM_REQ; burst_cnt <= 0.
- wfull=1 in HOLD: stall. No accept, no count; ownership is kept; exit only via (b) or (c).
- Latency: first write occurs 1 cycle after req is seen in IDLE. One IDLE bubble cycle separates consecutive grants.
- Requester protocol: once req[i]=1 it stays high with stable data until accepted. The arbiter does not check this.
- If only low-priority requesters are active while half_full=1, the arbiter stays in IDLE with no writes.
- Reset mid-HOLD: next edge returns to the reset state. A word not accepted that cycle is not written.
- NUM_REQ not a power of 2: rr_ptr and owner wrap from NUM_REQ-1 to 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum {IDLE, HOLD};
  - IDX_W = 3;
  - BURST_CNT_W = 4;
  - COUNT_W = 16.
- Sub-module rr_picker (combinational): inputs eligible and rr_ptr; outputs found and idx.
- Top module contains the FSM, counters and output mux.

Test Plan:
- Reset: hold wrst=1 for 3 cycles with req=4'b1111 -> winc=0, busy=0, req_ready=0, write_count=0 throughout.
- Single requester: req=4'b0001 held for 10 cycles, data 8'h10..8'h19 -> requester 0 pattern: 4 writes, 1 bubble, 4 writes, bubble, 2 writes; write_count=10; data in order.
- Rotation: req=4'b1111 continuously, BURST_LEN=4 -> grant_id sequence 0,1,2,3,0, with 4 winc pulses each and a 1-cycle gap between grants.
- Backpressure: owner 1 mid-burst, force wfull=1 for 5 cycles -> winc=0 and req_ready[1]=0 for those cycles; burst resumes after wfull drops with the same word; no duplicates; the count of 4 is preserved.
- Throttle: half_full=1 with req=4'b1001 -> only requester 0 is granted. Drop half_full -> requester 3 is granted next.
- Scoreboard: random req patterns over 2000 cycles feeding the real Async_FIFO, read side draining -> read sequence equals the per-requester accepted order; write_count equals total pops.
